// File: rtl/dff_scan_sequencer.sv
// Fixed-timing load/shift sequencer for a DFF chain readout, with per-lane
// saturating error counters and a completed-scan counter.
module dff_scan_sequencer #(
   parameter int unsigned LANES     = 10,
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned SHIFT_DIV = 4,
   parameter logic        EXP_VAL   = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RST_B,
   input  logic                   start,
   input  logic                   clear_cnt,
   input  logic [LANES-1:0]       q_in,
   output logic                   load_out,
   output logic                   shift_clk_out,
   output logic                   busy,
   output logic                   done,
   output logic [LANES*CNT_W-1:0] err_cnt,
   output logic [15:0]            scan_count
);

   localparam int unsigned DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
   localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                 state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic                   hi_q, hi_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic                   phase_end;
   logic                   sample;
   logic                   load_q, shclk_q, busy_q, done_q;
   logic [15:0]            scan_count_q;
   logic [LANES*CNT_W-1:0] err_q, err_d;

   assign phase_end = (div_q == DIV_LAST);

   // hi_q selects the high half of the current shift-clock period.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hi_d    = hi_q;
      bit_d   = bit_q;
      sample  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               div_d   = '0;
               hi_d    = 1'b0;
            end
         end
         StLoad: begin
            if (phase_end) begin
               div_d = '0;
               if (hi_q) begin
                  state_d = StShift;
                  hi_d    = 1'b0;
                  bit_d   = '0;
               end else begin
                  hi_d = 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StShift: begin
            sample = !hi_q && phase_end;
            if (phase_end) begin
               div_d = '0;
               if (hi_q) begin
                  hi_d  = 1'b0;
                  bit_d = bit_q + 1'b1;
               end else if (bit_q == BIT_LAST) begin
                  state_d = StDone;
               end else begin
                  hi_d = 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Clear takes priority over a coincident sample.
   always_comb begin
      err_d = err_q;
      if (clear_cnt) begin
         err_d = '0;
      end else if (sample) begin
         for (int unsigned n = 0; n < LANES; n++) begin
            if (q_in[n] != EXP_VAL && err_q[n*CNT_W +: CNT_W] != CNT_MAX) begin
               err_d[n*CNT_W +: CNT_W] = err_q[n*CNT_W +: CNT_W] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         state_q      <= StIdle;
         div_q        <= '0;
         hi_q         <= 1'b0;
         bit_q        <= '0;
         load_q       <= 1'b0;
         shclk_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         scan_count_q <= '0;
         err_q        <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         bit_q   <= bit_d;
         load_q  <= (state_d == StLoad);
         shclk_q <= hi_d && (state_d == StLoad || state_d == StShift);
         busy_q  <= (state_d == StLoad || state_d == StShift);
         done_q  <= (state_d == StDone);
         err_q   <= err_d;
         if (state_d == StDone) begin
            scan_count_q <= scan_count_q + 16'd1;
         end
      end
   end

   assign load_out      = load_q;
   assign shift_clk_out = shclk_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_cnt       = err_q;
   assign scan_count    = scan_count_q;

endmodule

// File: tb/tb_dff_scan_sequencer.sv
// Bench for dff_scan_sequencer: directed scans with random lane data, checked
// against a cycle-indexed model of the scan schedule and error counting.
module tb_dff_scan_sequencer;

   localparam int LANES = 10;

   logic         CLK = 1'b0;
   logic         RST_B;
   logic         start;
   logic         clear_cnt;
   logic [9:0]   q_in;
   logic         load_out, shift_clk_out, busy, done;
   logic [119:0] err_cnt;
   logic [15:0]  scan_count;
   logic         load4, shclk4, busy4, done4;
   logic [39:0]  err4;
   logic [15:0]  sc4;

   int          nchk = 0;
   int          nfail = 0;
   int          m12[LANES];
   int          m4[LANES];
   logic [15:0] m_sc;

   dff_scan_sequencer #(
      .LANES(10), .CHAIN_LEN(8), .CNT_W(12), .SHIFT_DIV(2), .EXP_VAL(1'b1)
   ) dut (
      .CLK(CLK), .RST_B(RST_B), .start(start), .clear_cnt(clear_cnt), .q_in(q_in),
      .load_out(load_out), .shift_clk_out(shift_clk_out), .busy(busy), .done(done),
      .err_cnt(err_cnt), .scan_count(scan_count)
   );

   dff_scan_sequencer #(
      .LANES(10), .CHAIN_LEN(8), .CNT_W(4), .SHIFT_DIV(2), .EXP_VAL(1'b1)
   ) dut4 (
      .CLK(CLK), .RST_B(RST_B), .start(start), .clear_cnt(clear_cnt), .q_in(q_in),
      .load_out(load4), .shift_clk_out(shclk4), .busy(busy4), .done(done4),
      .err_cnt(err4), .scan_count(sc4)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [127:0] pack(input int w);
      logic [127:0] v;
      v = '0;
      for (int n = 0; n < LANES; n++) begin
         if (w == 12) v[n*12 +: 12] = 12'(m12[n]);
         else         v[n*4 +: 4]   = 4'(m4[n]);
      end
      return v;
   endfunction

   task automatic model_clear();
      for (int n = 0; n < LANES; n++) begin
         m12[n] = 0;
         m4[n]  = 0;
      end
   endtask

   task automatic model_sample();
      for (int n = 0; n < LANES; n++) begin
         if (q_in[n] !== 1'b1) begin
            if (m12[n] < 4095) m12[n]++;
            if (m4[n] < 15)    m4[n]++;
         end
      end
   endtask

   task automatic drive_q(input int mode);
      logic [9:0] v;
      case (mode)
         1:       v = ~(10'd1 << 3);
         2:       v = 10'($urandom);
         3:       v = ~(10'd1 << 0);
         4:       v = ~(10'd1 << 5);
         default: v = '1;
      endcase
      q_in = v;
   endtask

   // Cycle c counts from the cycle in which start is presented (c=0).
   task automatic check_timing(input int c);
      logic exp_shclk;
      exp_shclk = (c >= 3 && c <= 4) || (c >= 5 && c <= 34 && ((c - 5) % 4) >= 2);
      chk($sformatf("c%0d load_out", c), load_out, (c >= 1 && c <= 4));
      chk($sformatf("c%0d shift_clk_out", c), shift_clk_out, exp_shclk);
      chk($sformatf("c%0d busy", c), busy, (c >= 1 && c <= 34));
      chk($sformatf("c%0d done", c), done, (c == 35));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " load_out"}, load_out, 0);
      chk({tag, " shift_clk_out"}, shift_clk_out, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err_cnt"}, err_cnt, 0);
      chk({tag, " scan_count"}, scan_count, 0);
      chk({tag, " err4"}, err4, 0);
      chk({tag, " busy4"}, busy4, 0);
   endtask

   task automatic run_scan(input int mode, input int clr_a, input int clr_b, input bit hold);
      start     = 1'b1;
      clear_cnt = 1'b0;
      drive_q(mode);
      step();
      for (int c = 1; c <= 36; c++) begin
         start = hold;
         drive_q(mode);
         clear_cnt = (c == clr_a) || (c == clr_b);
         if (!(hold && c == 36)) check_timing(c);
         if (c == 35) begin
            chk("err_cnt at done", err_cnt, pack(12));
            chk("err_cnt (4-bit) at done", err4, pack(4));
            m_sc = m_sc + 16'd1;
         end
         if (c == 36) chk("scan_count", scan_count, m_sc);
         if (clear_cnt) model_clear();
         else if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) model_sample();
         step();
      end
      start     = 1'b0;
      clear_cnt = 1'b0;
   endtask

   initial begin
      int nd;
      m_sc = '0;
      model_clear();
      RST_B     = 1'b0;
      start     = 1'b0;
      clear_cnt = 1'b0;
      q_in      = '1;
      #3;
      check_zero("por");
      repeat (2) step();
      RST_B = 1'b1;
      step();

      // Basic timing, all lanes good
      run_scan(0, -1, -1, 1'b0);
      // Single failing lane, accumulating over two scans
      run_scan(1, -1, -1, 1'b0);
      run_scan(1, -1, -1, 1'b0);

      clear_cnt = 1'b1;
      step();
      clear_cnt = 1'b0;
      model_clear();
      chk("clear idle", err_cnt, 0);

      // Saturation of the 4-bit instance
      repeat (3) run_scan(3, -1, -1, 1'b0);

      // Clear held across the bit-7 sample: clear must win
      run_scan(4, 33, 34, 1'b0);

      // Random lane data, one scan with a clear on the bit-4 sample
      repeat (3) run_scan(2, -1, -1, 1'b0);
      run_scan(2, 22, 22, 1'b0);
      run_scan(2, -1, -1, 1'b0);

      // Reset mid-scan
      start = 1'b1;
      drive_q(1);
      step();
      start = 1'b0;
      repeat (14) step();
      RST_B = 1'b0;
      #1;
      check_zero("mid-scan reset");
      model_clear();
      m_sc = '0;
      step();
      RST_B = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) nd++;
         step();
      end
      chk("no activity after abort", nd, 0);
      run_scan(0, -1, -1, 1'b0);

      // scan_count wrap and start held through a scan
      force dut.scan_count_q = 16'hFFFF;
      step();
      release dut.scan_count_q;
      step();
      m_sc = 16'hFFFF;
      chk("scan_count preset", scan_count, m_sc);
      run_scan(0, -1, -1, 1'b1);
      chk("restart load_out", load_out, 1);
      chk("restart busy", busy, 1);
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) nd++;
         step();
      end
      chk("single second scan", nd, 1);
      m_sc = m_sc + 16'd1;
      chk("scan_count after wrap", scan_count, m_sc);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
